// File: rtl/minmax_job_arbiter.sv
// minmax_job_arbiter
//   Round-robin arbiter/sequencer that shares one max-difference unit among
//   N_REQ requesters. A job is granted, the unit is started with a one-cycle
//   go pulse, and the job is acknowledged when the unit signals completion.
//   If the unit never completes, a watchdog resets the unit and the job is
//   acknowledged with err=1.
//
// Ports
//   Clk, Rst       : clock (rising edge), asynchronous active-low reset
//   req[N_REQ]     : level requests, held until the matching ack
//   ack[N_REQ]     : one-hot, one-cycle acknowledge; result/err valid with it
//   result[W]      : captured unit result (0 on timeout), held until next ack
//   err            : job timed out (valid with ack)
//   busy           : high whenever not IDLE
//   grant_id       : current / last granted requester index
//   unit_go        : one-cycle start pulse to the shared unit
//   unit_rst       : active-high recovery reset to the shared unit
//   unit_done      : unit completion level
//   unit_max_diff  : unit result, valid while unit_done is high
module minmax_job_arbiter #(
    parameter int N_REQ   = 4,
    parameter int W       = 8,
    parameter int TIMEOUT = 64,
    parameter int RCV_CYC = 2
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic [N_REQ-1:0]         req,
    output logic [N_REQ-1:0]         ack,
    output logic [W-1:0]             result,
    output logic                     err,
    output logic                     busy,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     unit_go,
    output logic                     unit_rst,
    input  logic                     unit_done,
    input  logic [W-1:0]             unit_max_diff
);

    localparam int IDW = $clog2(N_REQ);
    localparam int TW  = $clog2(TIMEOUT) + 1;
    localparam int RW  = $clog2(RCV_CYC) + 1;

    localparam logic [TW-1:0]  T_LAST  = TW'(TIMEOUT - 1);
    localparam logic [RW-1:0]  R_LAST  = RW'(RCV_CYC - 1);
    localparam logic [IDW-1:0] ID_LAST = IDW'(N_REQ - 1);

    typedef enum logic [2:0] {IDLE, GO, WAIT, RECOVER, ACK} state_t;

    state_t           state, state_n;
    logic [IDW-1:0]   last, last_n;
    logic [IDW-1:0]   grant_n;
    logic [TW-1:0]    timer, timer_n;
    logic [RW-1:0]    rcv_cnt, rcv_n;
    logic             done_q;
    logic             mask_q;     // first IDLE cycle after ACK: hide req[last]

    logic [N_REQ-1:0] ack_n;
    logic [W-1:0]     result_n;
    logic             err_n;

    // round-robin pick, searching last+1, last+2, ... with wrap
    logic [N_REQ-1:0] req_m;
    logic             found;
    logic [IDW-1:0]   pick;
    logic [IDW-1:0]   cand;
    int               idx;

    always_comb begin
        req_m = req;
        if (mask_q)
            req_m[last] = 1'b0;
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        idx   = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx  = (int'(last) + i) % N_REQ;
            cand = IDW'(idx);
            if (!found && req_m[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // next-state and next-output logic; every output is a registered copy
    always_comb begin
        state_n  = state;
        last_n   = last;
        grant_n  = grant_id;
        timer_n  = timer;
        rcv_n    = rcv_cnt;
        result_n = result;
        err_n    = err;
        ack_n    = '0;

        case (state)
            IDLE: begin
                if (found) begin
                    grant_n = pick;
                    state_n = GO;
                end
            end
            GO: begin
                timer_n = '0;
                state_n = WAIT;
            end
            WAIT: begin
                // only a rising edge of unit_done counts, so a level left
                // high by the previous job cannot complete this one;
                // completion takes priority over the timeout
                if (unit_done && !done_q) begin
                    result_n = unit_max_diff;
                    err_n    = 1'b0;
                    state_n  = ACK;
                end else if (timer == T_LAST) begin
                    rcv_n   = '0;
                    state_n = RECOVER;
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            RECOVER: begin
                if (rcv_cnt == R_LAST) begin
                    result_n = '0;
                    err_n    = 1'b1;
                    state_n  = ACK;
                end else begin
                    rcv_n = rcv_cnt + RW'(1);
                end
            end
            ACK: begin
                last_n  = grant_id;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        if (state_n == ACK)
            ack_n[grant_n] = 1'b1;
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state    <= IDLE;
            last     <= ID_LAST;
            timer    <= '0;
            rcv_cnt  <= '0;
            done_q   <= 1'b0;
            mask_q   <= 1'b0;
            ack      <= '0;
            result   <= '0;
            err      <= 1'b0;
            busy     <= 1'b0;
            grant_id <= '0;
            unit_go  <= 1'b0;
            unit_rst <= 1'b0;
        end else begin
            state    <= state_n;
            last     <= last_n;
            timer    <= timer_n;
            rcv_cnt  <= rcv_n;
            done_q   <= unit_done;
            mask_q   <= (state == ACK);
            ack      <= ack_n;
            result   <= result_n;
            err      <= err_n;
            busy     <= (state_n != IDLE);
            grant_id <= grant_n;
            unit_go  <= (state_n == GO);
            unit_rst <= (state_n == RECOVER);
        end
    end

endmodule

// File: tb/tb_minmax_job_arbiter.sv
// Bench for minmax_job_arbiter: table of single jobs (including a timeout)
// plus hand sequences for simultaneous requests, fairness, stale done and
// reset in the middle of a job. A small behavioural unit model answers go.
module tb_minmax_job_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int TO = 16;
    localparam int RC = 2;

    logic         Clk = 1'b0;
    logic         Rst = 1'b0;
    logic [N-1:0] req = '0;
    logic [N-1:0] ack;
    logic [W-1:0] result;
    logic         err;
    logic         busy;
    logic [1:0]   grant_id;
    logic         unit_go;
    logic         unit_rst;
    logic         unit_done = 1'b0;
    logic [W-1:0] unit_max_diff = '0;

    minmax_job_arbiter #(.N_REQ(N), .W(W), .TIMEOUT(TO), .RCV_CYC(RC)) dut (
        .Clk(Clk), .Rst(Rst), .req(req), .ack(ack), .result(result),
        .err(err), .busy(busy), .grant_id(grant_id), .unit_go(unit_go),
        .unit_rst(unit_rst), .unit_done(unit_done), .unit_max_diff(unit_max_diff)
    );

    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;

    // unit model: done rises mlat cycles after go (mlat=0: never)
    bit           model_en = 1'b1;
    int           mlat = 1;
    logic [W-1:0] mdata = '0;
    int           mcnt = 0;

    always @(negedge Clk) begin
        if (model_en) begin
            if (unit_go) begin
                mcnt      = mlat;
                unit_done = 1'b0;
            end else if (mcnt > 0) begin
                mcnt = mcnt - 1;
                if (mcnt == 0) begin
                    unit_done     = 1'b1;
                    unit_max_diff = mdata;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ack"},      ack, 0);
        chk({tag, "_result"},   result, 0);
        chk({tag, "_err"},      err, 0);
        chk({tag, "_busy"},     busy, 0);
        chk({tag, "_grant_id"}, grant_id, 0);
        chk({tag, "_unit_go"},  unit_go, 0);
        chk({tag, "_unit_rst"}, unit_rst, 0);
    endtask

    typedef struct {
        logic [N-1:0] req;
        int           lat;
        logic [W-1:0] data;
        logic [1:0]   grant;
        logic [W-1:0] res;
        logic         err;
    } vec_t;

    task automatic run_job(input vec_t v);
        int           go_t, ack_t, gos, rsts, exp_lat;
        bit           got;
        logic [N-1:0] a;
        logic [W-1:0] r;
        logic         e;
        logic [1:0]   g;
        got = 0; gos = 0; rsts = 0; go_t = -1; ack_t = -1;
        a = '0; r = '0; e = 1'b0; g = '0;
        exp_lat = (v.lat == 0) ? (TO + RC + 1) : (v.lat + 1);
        @(negedge Clk);
        mlat = v.lat; mdata = v.data; req = v.req;
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge Clk);
            if (unit_go) begin
                gos++;
                if (go_t < 0) go_t = c;
            end
            if (unit_rst) rsts++;
            if (|ack) begin
                got = 1; ack_t = c; a = ack; r = result; e = err; g = grant_id;
            end
        end
        req = '0;
        chk("job_ack_seen", 32'(got), 1);
        chk("job_ack_onehot", a, v.req);
        chk("job_grant", g, v.grant);
        chk("job_result", r, v.res);
        chk("job_err", e, v.err);
        chk("job_go_pulses", gos, 1);
        chk("job_req_to_go", go_t, 0);
        chk("job_unit_rst_cycles", rsts, (v.lat == 0) ? RC : 0);
        chk("job_go_to_ack", ack_t - go_t, exp_lat);
        @(negedge Clk);
        chk("job_ack_one_cycle", ack, 0);
        chk("job_busy_idle", busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t         tbl[6];
        int           gcnt, gos, viol, early;
        bit           outst, seen, got;
        logic [1:0]   order[8];
        logic [N-1:0] raise;

        tbl[0] = '{req: 4'b0100, lat: 5, data: 8'h3C, grant: 2'd2, res: 8'h3C, err: 1'b0};
        tbl[1] = '{req: 4'b0001, lat: 1, data: 8'hFF, grant: 2'd0, res: 8'hFF, err: 1'b0};
        tbl[2] = '{req: 4'b1000, lat: 3, data: 8'h00, grant: 2'd3, res: 8'h00, err: 1'b0};
        tbl[3] = '{req: 4'b0010, lat: 8, data: 8'hA5, grant: 2'd1, res: 8'hA5, err: 1'b0};
        tbl[4] = '{req: 4'b0001, lat: 0, data: 8'h99, grant: 2'd0, res: 8'h00, err: 1'b1};
        tbl[5] = '{req: 4'b0100, lat: 2, data: 8'h5A, grant: 2'd2, res: 8'h5A, err: 1'b0};

        // reset state
        repeat (2) @(negedge Clk);
        chk_reset_outputs("reset");
        Rst = 1'b1;

        // simultaneous requests after reset: 0,1,2,3, one go per ack
        @(negedge Clk);
        mlat = 3; mdata = 8'h42; req = 4'hF;
        gcnt = 0; gos = 0; viol = 0; outst = 0;
        for (int c = 0; c < 400 && gcnt < 4; c++) begin
            @(negedge Clk);
            if (unit_go) begin
                gos++;
                if (outst) viol++;
                outst = 1;
            end
            if (|ack) begin
                order[gcnt] = grant_id;
                gcnt++;
                outst = 0;
                req = req & ~ack;
            end
        end
        req = '0;
        chk("simul_ack_count", gcnt, 4);
        for (int i = 0; i < 4; i++) chk("simul_order", order[i], i);
        chk("simul_go_count", gos, 4);
        chk("simul_go_overlap", viol, 0);
        @(negedge Clk);

        // single jobs, including the timeout and the job after it
        for (int i = 0; i < 6; i++) run_job(tbl[i]);

        // fairness: req0 and req2 re-raise right after each ack
        @(negedge Clk); Rst = 1'b0;
        @(negedge Clk); Rst = 1'b1;
        mlat = 2; mdata = 8'h10; req = 4'b0101; raise = '0; gcnt = 0;
        for (int c = 0; c < 600 && gcnt < 6; c++) begin
            @(negedge Clk);
            if (raise != '0) begin
                req = req | raise;
                raise = '0;
            end
            if (|ack) begin
                order[gcnt] = grant_id;
                gcnt++;
                req = req & ~ack;
                raise = ack;
            end
        end
        req = '0;
        chk("fair_ack_count", gcnt, 6);
        for (int i = 0; i < 6; i++) chk("fair_order", order[i], (i % 2 == 0) ? 0 : 2);
        repeat (3) @(negedge Clk);
        chk("fair_busy_idle", busy, 0);

        // stale done: level left high from before must not complete the job
        @(negedge Clk);
        model_en = 0; unit_done = 1'b1; unit_max_diff = 8'hEE; req = 4'b0010;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge Clk);
            if (unit_go) seen = 1;
        end
        chk("stale_go_seen", 32'(seen), 1);
        early = 0;
        @(negedge Clk); if (|ack) early++;
        @(negedge Clk); if (|ack) early++;
        unit_done = 1'b0;
        repeat (4) begin
            @(negedge Clk);
            if (|ack) early++;
        end
        unit_done = 1'b1; unit_max_diff = 8'h11;
        got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge Clk);
            if (|ack) begin
                got = 1;
                chk("stale_result", result, 8'h11);
                chk("stale_err", err, 0);
                chk("stale_ack", ack, 4'b0010);
            end
        end
        req = '0;
        chk("stale_ack_seen", 32'(got), 1);
        chk("stale_early_ack", early, 0);
        @(negedge Clk);
        unit_done = 1'b0; model_en = 1;

        // asynchronous reset in the middle of WAIT
        @(negedge Clk);
        mlat = 0; req = 4'b1000;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge Clk);
            if (unit_go) seen = 1;
        end
        chk("rstmid_go_seen", 32'(seen), 1);
        req = '0;
        repeat (3) @(negedge Clk);
        chk("rstmid_busy_before", busy, 1);
        #2 Rst = 1'b0;
        #1 chk_reset_outputs("rstmid");
        early = 0;
        repeat (2) begin
            @(negedge Clk);
            if (|ack) early++;
        end
        chk("rstmid_no_ack", early, 0);
        mlat = 2; mdata = 8'h77; req = 4'b1010; Rst = 1'b1;
        got = 0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge Clk);
            if (|ack) begin
                got = 1;
                chk("rstmid_first_grant", grant_id, 1);
                chk("rstmid_first_ack", ack, 4'b0010);
                chk("rstmid_first_result", result, 8'h77);
            end
        end
        req = '0;
        chk("rstmid_ack_seen", 32'(got), 1);
        repeat (3) @(negedge Clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
